difftest_arch_event_arbiter: RTL
================================

Name: difftest_arch_event_arbiter

Overview:
- Shares one DifftestArchEvent DPI sink between NUM_REQ architectural-event producers, e.g. per-core commit/trap units or the interrupt and exception paths of one core.
- Arbitrates round-robin over valid/ready requesters and buffers granted events in a FIFO.
- Presents at most one event per cycle to the sink, as a payload bundle plus a single-cycle enable.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- FIFO_DEPTH, 4, event buffer entries (power of two, >=2).
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width (derived).
- EVT_W, 170, payload width: interrupt 32, exception 32, exceptionPC 64, exceptionInst 32, hasNMI 1, virtualInterruptIsHvictlInject 1, coreid 8, packed MSB-first in that order.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester event valid.
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high.
- req_event  in  NUM_REQ*EVT_W  flattened payloads; requester i occupies bits [i*EVT_W +: EVT_W].
- out_ready  in  1  sink can take an event this cycle; tie high for a DPI sink.
- out_enable  out  1  event presented and consumed this cycle; drives the sink enable.
- out_interrupt  out  32  payload field.
- out_exception  out  32  payload field.
- out_exceptionPC  out  64  payload field.
- out_exceptionInst  out  32  payload field.
- out_hasNMI  out  1  payload field.
- out_virtualInterruptIsHvictlInject  out  1  payload field.
- out_coreid  out  8  payload field.
- fifo_count  out  PTR_W+1  current occupancy.
- event_count  out  32  total events emitted.

Behaviour:
- Reset (reset_n low, async):
  - all FIFO pointers and occupancy clear to 0; rr_ptr clears to 0; event_count clears to 0.
  - req_ready and out_enable read 0; payload outputs read 0.
  - FIFO contents are not reset and are not visible while the FIFO is empty.
  - Reset asserted mid-operation discards all buffered events; no out_enable pulse occurs during or in the cycle after reset release unless a new event has been accepted.
- Arbitration (combinational, each cycle):
  - grant goes to the first requester with req_valid=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[i] = grant[i] && !full. At most one req_ready bit is high per cycle.
  - req_ready depends only on req_valid and state; valid may depend on ready.
- Pointer update: on an accepted transfer from requester g, rr_ptr <= (g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- FIFO:
  - push on transfer, writing the granted req_event at the write pointer; pop when out_enable.
  - full = (count==FIFO_DEPTH); empty = (count==0).
  - pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged. This can only happen when not full, because ready is gated by full rather than full&&!pop, so there is no same-cycle refill while full.
  - No bypass: an event accepted in cycle T is presented no earlier than cycle T+1. Latency when empty with out_ready=1 is exactly 1 cycle.
- Output:
  - out_enable = !empty && out_ready.
  - payload outputs = FIFO head when !empty, else 0.
  - payload is held stable while out_ready=0.
  - out_enable is never asserted with empty FIFO.
- event_count increments by 1 on each out_enable and wraps 0xFFFFFFFF -> 0.
- Ordering:
  - events from one requester emerge in acceptance order; across requesters, in acceptance order.
  - no event is dropped or duplicated.
- Fairness: with all requesters continuously valid and out_ready=1, grants rotate 0,1,..,NUM_REQ-1. No requester waits more than NUM_REQ-1 grants of others.

Test Plan:
- Single event: reset, then req0 valid with exceptionPC=0x8000_0000, exception=2, coreid=0 for 1 cycle. Required: req_ready[0]=1 that cycle; out_enable=1 exactly one cycle later with the same fields; event_count=1; fifo_count back to 0.
- Round-robin: NUM_REQ=2, both valid continuously with distinct coreid 0/1, out_ready=1 for 8 cycles. Required: grants alternate 0,1,0,1,...; out_coreid sequence 0,1,0,1 delayed 1 cycle; event_count=8.
- Backpressure/full: out_ready=0, req0 valid with 5 events. Required: 4 accepted, fifo_count=4, req_ready[0]=0 on the 5th. Then out_ready=1: first out_enable next cycle; heads emitted in order 1..4; 5th accepted only after count<4.
- Simultaneous push/pop at count=2: count stays 2 and order is preserved.
- Reset mid-stream: fifo_count=3, assert reset_n=0 for 1 cycle. Required: fifo_count=0, out_enable=0, event_count=0, rr_ptr=0; the next accepted event emerges correctly.
- Counter wrap: force event_count to 0xFFFFFFFF (via bind/force), emit 1 event. Required: event_count=0.

Source files
------------

// File: rtl/difftest_arch_event_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ DifftestArchEvent producers into one
// DPI sink through a small FIFO, presenting at most one event per cycle.
module difftest_arch_event_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH),
  parameter int EVT_W      = 170
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*EVT_W-1:0] req_event,
  input  logic                     out_ready,
  output logic                     out_enable,
  output logic [31:0]              out_interrupt,
  output logic [31:0]              out_exception,
  output logic [63:0]              out_exceptionPC,
  output logic [31:0]              out_exceptionInst,
  output logic                     out_hasNMI,
  output logic                     out_virtualInterruptIsHvictlInject,
  output logic [7:0]               out_coreid,
  output logic [PTR_W:0]           fifo_count,
  output logic [31:0]              event_count
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [RR_W-1:0] LAST_C  = RR_W'(NUM_REQ - 1);

  logic [EVT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic [RR_W-1:0]    r_rr;
  logic [31:0]        r_evt_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_found;
  logic               w_push;
  logic               w_pop;
  logic [RR_W-1:0]    w_gidx;
  logic [NUM_REQ-1:0] w_grant;
  logic [EVT_W-1:0]   w_push_evt;
  logic [EVT_W-1:0]   w_head;

  // Winner is the valid requester at the smallest rotational distance from r_rr.
  always_comb begin
    int unsigned v_best;
    int unsigned v_d;
    w_found = 1'b0;
    w_gidx  = '0;
    v_best  = NUM_REQ;
    v_d     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      v_d = (i + NUM_REQ - 32'(r_rr)) % NUM_REQ;
      if (req_valid[i] && (v_d < v_best)) begin
        v_best  = v_d;
        w_gidx  = RR_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant    = '0;
    w_push_evt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_gidx == RR_W'(i))) begin
        w_grant[i] = 1'b1;
        w_push_evt = req_event[i*EVT_W +: EVT_W];
      end
    end
  end

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  // Ready is gated by reset so no handshake is offered while the block is held in reset.
  assign req_ready  = reset_n ? (w_grant & ~{NUM_REQ{w_full}}) : '0;
  assign w_push     = reset_n && w_found && !w_full;
  assign w_pop      = !w_empty && out_ready;
  assign out_enable = w_pop;

  assign w_head = w_empty ? '0 : r_mem[r_rptr];
  assign out_interrupt                      = w_head[169:138];
  assign out_exception                      = w_head[137:106];
  assign out_exceptionPC                    = w_head[105:42];
  assign out_exceptionInst                  = w_head[41:10];
  assign out_hasNMI                         = w_head[9];
  assign out_virtualInterruptIsHvictlInject = w_head[8];
  assign out_coreid                         = w_head[7:0];

  assign fifo_count  = r_count;
  assign event_count = r_evt_cnt;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_evt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rr      <= '0;
      r_evt_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
        r_rr   <= (w_gidx == LAST_C) ? '0 : w_gidx + 1'b1;
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        r_evt_cnt <= r_evt_cnt + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
